// File: rtl/bc_io_pkg.sv
// Shared definitions for the programmed-I/O interrupt unit:
// default parameters, vector encoding and per-channel state record.
package bc_io_pkg;

    localparam int          DEF_NCH      = 4;
    localparam int          DEF_DATA_W   = 8;
    localparam int          DEF_ADDR_W   = 12;
    localparam logic [11:0] DEF_VEC_BASE = 12'h001;

    // Widest character a channel record can carry.
    localparam int MAX_DATA_W = 64;

    localparam int VEC_STRIDE  = 2;
    localparam int VEC_IN_OFS  = 0;
    localparam int VEC_OUT_OFS = 1;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] inpr;
        logic [MAX_DATA_W-1:0] outr;
        logic                  fgi;
        logic                  fgo;
        logic                  ovr;
        logic                  out_valid;
    } chan_state_t;

    function automatic int vec_offset(input int ch, input logic is_out);
        return ch * VEC_STRIDE + (is_out ? VEC_OUT_OFS : VEC_IN_OFS);
    endfunction

endpackage

// File: rtl/io_interrupt_unit_if.sv
// CPU-side register access bus of the I/O interrupt unit.
// The CPU drives the master side, the unit is the slave.
interface io_interrupt_unit_if
    import bc_io_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int DATA_W = DEF_DATA_W
);

    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SEL_W-1:0]  cpu_sel;
    logic              cpu_inp_rd;
    logic              cpu_out_wr;
    logic              cpu_mask_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_sel,
        output cpu_inp_rd,
        output cpu_out_wr,
        output cpu_mask_wr,
        output cpu_wdata,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_sel,
        input  cpu_inp_rd,
        input  cpu_out_wr,
        input  cpu_mask_wr,
        input  cpu_wdata,
        output cpu_rdata
    );

endinterface

// File: rtl/io_channel.sv
// One I/O channel: input register with ready/overrun flags and
// output register with a valid/ready hand-off to the device.
module io_channel
    import bc_io_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              inp_rd,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              out_ready,
    output chan_state_t       state
);

    chan_state_t st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= '0;
            st.fgo <= 1'b1;
        end else begin
            if (inp_rd) begin
                st.fgi <= 1'b0;
                st.ovr <= 1'b0;
            end
            // A read in the same cycle frees the register for the new char.
            if (in_valid) begin
                if (st.fgi && !inp_rd) begin
                    st.ovr <= 1'b1;
                end else begin
                    st.inpr <= MAX_DATA_W'(in_data);
                    st.fgi  <= 1'b1;
                end
            end
            if (st.out_valid && out_ready) begin
                st.out_valid <= 1'b0;
                st.fgo       <= 1'b1;
            end
            // fgo=1 implies no char pending, so this never races the hand-off.
            if (out_wr && st.fgo) begin
                st.outr      <= MAX_DATA_W'(wdata);
                st.fgo       <= 1'b0;
                st.out_valid <= 1'b1;
            end
        end
    end

    assign state = st;

endmodule

// File: rtl/io_interrupt_unit.sv
// Multi-channel programmed-I/O unit with masked, prioritised
// interrupt request and frozen service vector.
module io_interrupt_unit
    import bc_io_pkg::*;
#(
    parameter int                NCH      = DEF_NCH,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(DEF_VEC_BASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*DATA_W-1:0] dev_in_data,
    input  logic [NCH-1:0]        dev_in_valid,
    output logic [NCH*DATA_W-1:0] dev_out_data,
    output logic [NCH-1:0]        dev_out_valid,
    input  logic [NCH-1:0]        dev_out_ready,
    io_interrupt_unit_if.slave    cpu,
    output logic [NCH-1:0]        fgi,
    output logic [NCH-1:0]        fgo,
    output logic [NCH-1:0]        ovr,
    input  logic                  ien_set,
    input  logic                  ien_clr,
    output logic                  ien,
    input  logic                  seq_t012,
    output logic                  r,
    input  logic                  int_ack,
    output logic [ADDR_W-1:0]     int_vector
);

    chan_state_t       st     [NCH];
    logic [DATA_W-1:0] inpr_v [NCH];
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    pend_in;
    logic [NCH-1:0]    pend_out;
    logic              sel_ok;
    logic [ADDR_W-1:0] src_off;

    assign sel_ok = int'(cpu.cpu_sel) < NCH;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        logic unused_hi;

        assign hit = sel_ok && (int'(cpu.cpu_sel) == i);

        io_channel #(
            .DATA_W(DATA_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .in_data  (dev_in_data[i*DATA_W +: DATA_W]),
            .in_valid (dev_in_valid[i]),
            .inp_rd   (hit && cpu.cpu_inp_rd),
            .out_wr   (hit && cpu.cpu_out_wr),
            .wdata    (cpu.cpu_wdata),
            .out_ready(dev_out_ready[i]),
            .state    (st[i])
        );

        assign fgi[i]           = st[i].fgi;
        assign fgo[i]           = st[i].fgo;
        assign ovr[i]           = st[i].ovr;
        assign dev_out_valid[i] = st[i].out_valid;
        assign inpr_v[i]        = st[i].inpr[DATA_W-1:0];

        assign dev_out_data[i*DATA_W +: DATA_W] = st[i].outr[DATA_W-1:0];

        assign unused_hi = ^{st[i].inpr[MAX_DATA_W-1:DATA_W],
                             st[i].outr[MAX_DATA_W-1:DATA_W]};
    end

    always_comb begin
        cpu.cpu_rdata = '0;
        if (sel_ok) begin
            cpu.cpu_rdata = inpr_v[cpu.cpu_sel];
        end
    end

    assign pend_in  = fgi & mask;
    assign pend_out = fgo & mask;

    // Scan from the top so the lowest channel, input first, wins.
    always_comb begin
        src_off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_out[i]) begin
                src_off = ADDR_W'(vec_offset(i, 1'b1));
            end
            if (pend_in[i]) begin
                src_off = ADDR_W'(vec_offset(i, 1'b0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '1;
        end else if (cpu.cpu_mask_wr && sel_ok) begin
            mask <= cpu.cpu_wdata[NCH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ien <= 1'b0;
        end else if (ien_clr || int_ack) begin
            ien <= 1'b0;
        end else if (ien_set) begin
            ien <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r          <= 1'b0;
            int_vector <= VEC_BASE;
        end else if (int_ack) begin
            r <= 1'b0;
        end else if (!seq_t012 && ien && !r && (|(pend_in | pend_out))) begin
            r          <= 1'b1;
            int_vector <= VEC_BASE + src_off;
        end
    end

endmodule

// File: tb/tb_io_interrupt_unit.sv
// Directed and randomised checks of io_interrupt_unit against a
// cycle-level behavioural model of the programmed-I/O rules.
module tb_io_interrupt_unit;

    localparam int          NCH    = 4;
    localparam int          DATA_W = 8;
    localparam int          ADDR_W = 12;
    localparam logic [11:0] VB     = 12'h001;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NCH*DATA_W-1:0] dev_in_data = '0;
    logic [NCH-1:0]        dev_in_valid = '0;
    logic [NCH*DATA_W-1:0] dev_out_data;
    logic [NCH-1:0]        dev_out_valid;
    logic [NCH-1:0]        dev_out_ready = '0;
    logic [NCH-1:0]        fgi, fgo, ovr;
    logic                  ien_set = 1'b0, ien_clr = 1'b0, ien;
    logic                  seq_t012 = 1'b1;
    logic                  r;
    logic                  int_ack = 1'b0;
    logic [ADDR_W-1:0]     int_vector;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    io_interrupt_unit_if #(.NCH(NCH), .DATA_W(DATA_W)) bus ();

    io_interrupt_unit #(
        .NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_BASE(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
        .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid),
        .dev_out_ready(dev_out_ready), .cpu(bus),
        .fgi(fgi), .fgo(fgo), .ovr(ovr),
        .ien_set(ien_set), .ien_clr(ien_clr), .ien(ien),
        .seq_t012(seq_t012), .r(r), .int_ack(int_ack),
        .int_vector(int_vector)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model state
    logic [7:0]     m_inpr [NCH];
    logic [7:0]     m_outr [NCH];
    logic [NCH-1:0] m_fgi, m_fgo, m_ovr, m_ov, m_mask;
    logic [NCH-1:0] o_fgi, o_fgo, o_ov;
    logic           m_r, m_ien;
    logic [11:0]    m_vec;
    bit             rd, wr, found;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_inpr[i] = 8'h00;
                m_outr[i] = 8'h00;
            end
            m_fgi = '0; m_fgo = '1; m_ovr = '0; m_ov = '0;
            m_mask = '1; m_r = 1'b0; m_ien = 1'b0; m_vec = VB;
        end else begin
            o_fgi = m_fgi; o_fgo = m_fgo; o_ov = m_ov;
            for (int i = 0; i < NCH; i++) begin
                rd = bus.cpu_inp_rd && (int'(bus.cpu_sel) == i);
                wr = bus.cpu_out_wr && (int'(bus.cpu_sel) == i);
                if (rd) begin
                    m_fgi[i] = 1'b0;
                    m_ovr[i] = 1'b0;
                end
                if (dev_in_valid[i]) begin
                    if (o_fgi[i] && !rd) m_ovr[i] = 1'b1;
                    else begin
                        m_inpr[i] = dev_in_data[i*8 +: 8];
                        m_fgi[i] = 1'b1;
                    end
                end
                if (o_ov[i] && dev_out_ready[i]) begin
                    m_ov[i] = 1'b0;
                    m_fgo[i] = 1'b1;
                end
                if (wr && o_fgo[i]) begin
                    m_outr[i] = bus.cpu_wdata;
                    m_fgo[i] = 1'b0;
                    m_ov[i] = 1'b1;
                end
            end
            // Sources listed as 0:in0 1:out0 2:in1 ...; first pending one wins.
            if (int_ack) m_r = 1'b0;
            else if (!seq_t012 && m_ien && !m_r) begin
                found = 1'b0;
                for (int k = 0; k < 2 * NCH; k++) begin
                    if (!found && m_mask[k/2] &&
                        ((k % 2 == 0) ? o_fgi[k/2] : o_fgo[k/2])) begin
                        found = 1'b1;
                        m_r = 1'b1;
                        m_vec = VB + 12'(k);
                    end
                end
            end
            if (ien_clr || int_ack) m_ien = 1'b0;
            else if (ien_set) m_ien = 1'b1;
            if (bus.cpu_mask_wr) m_mask = bus.cpu_wdata[NCH-1:0];
        end
    end

    logic [NCH*DATA_W-1:0] exp_od;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) exp_od[i*8 +: 8] = m_outr[i];
            check("fgi", 32'(fgi), 32'(m_fgi));
            check("fgo", 32'(fgo), 32'(m_fgo));
            check("ovr", 32'(ovr), 32'(m_ovr));
            check("out_valid", 32'(dev_out_valid), 32'(m_ov));
            check("out_data", dev_out_data, exp_od);
            check("r", 32'(r), 32'(m_r));
            check("ien", 32'(ien), 32'(m_ien));
            check("int_vector", 32'(int_vector), 32'(m_vec));
            check("cpu_rdata", 32'(bus.cpu_rdata),
                  32'(m_inpr[bus.cpu_sel]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        reset = 1'b0;
        dev_in_valid = '0;
        bus.cpu_inp_rd = 1'b0;
        bus.cpu_out_wr = 1'b0;
        bus.cpu_mask_wr = 1'b0;
        ien_set = 1'b0;
        ien_clr = 1'b0;
        int_ack = 1'b0;
    endtask

    initial begin
        bus.cpu_sel = '0;
        bus.cpu_inp_rd = 1'b0;
        bus.cpu_out_wr = 1'b0;
        bus.cpu_mask_wr = 1'b0;
        bus.cpu_wdata = '0;
        reset = 1'b1;
        cyc();
        chk_en = 1'b1;
        check("rst_fgi", 32'(fgi), 32'h0);
        check("rst_fgo", 32'(fgo), 32'hF);
        check("rst_valid", 32'(dev_out_valid), 32'h0);
        check("rst_r_ien", 32'({r, ien}), 32'h0);
        check("rst_vec", 32'(int_vector), 32'h001);

        // Input capture and read
        dev_in_data[23:16] = 8'h41; dev_in_valid = 4'b0100; cyc();
        check("in_fgi", 32'(fgi), 32'h4);
        bus.cpu_sel = 2'd2; #1;
        check("in_rdata", 32'(bus.cpu_rdata), 32'h41);
        bus.cpu_inp_rd = 1'b1; cyc();
        check("in_clr", 32'(fgi), 32'h0);

        // Overrun, then read racing a strobe
        bus.cpu_sel = 2'd0;
        dev_in_data[7:0] = 8'h31; dev_in_valid = 4'b0001; cyc();
        dev_in_data[7:0] = 8'h32; dev_in_valid = 4'b0001; cyc();
        check("ovr_data", 32'(bus.cpu_rdata), 32'h31);
        check("ovr_flag", 32'(ovr[0]), 32'h1);
        bus.cpu_inp_rd = 1'b1; dev_in_valid = 4'b0001; cyc();
        check("race_data", 32'(bus.cpu_rdata), 32'h32);
        check("race_ovr", 32'(ovr[0]), 32'h0);
        check("race_fgi", 32'(fgi[0]), 32'h1);
        bus.cpu_inp_rd = 1'b1; cyc();

        // Output hand-off
        bus.cpu_sel = 2'd1; bus.cpu_wdata = 8'h5A; bus.cpu_out_wr = 1'b1;
        cyc();
        check("out_fgo", 32'(fgo[1]), 32'h0);
        check("out_valid1", 32'(dev_out_valid[1]), 32'h1);
        repeat (5) cyc();
        check("out_hold", 32'(dev_out_valid[1]), 32'h1);
        bus.cpu_wdata = 8'hA5; bus.cpu_out_wr = 1'b1; cyc();
        check("out_ignored", 32'(dev_out_data[15:8]), 32'h5A);
        dev_out_ready[1] = 1'b1; cyc(); dev_out_ready[1] = 1'b0;
        check("out_done_fgo", 32'(fgo[1]), 32'h1);
        check("out_done_v", 32'(dev_out_valid[1]), 32'h0);

        // Priority: ch1 output beats ch3 input once ch0 output is busy
        bus.cpu_sel = 2'd0; bus.cpu_wdata = 8'hC3; bus.cpu_out_wr = 1'b1;
        dev_in_data[31:24] = 8'h77; dev_in_valid = 4'b1000; ien_set = 1'b1;
        cyc();
        check("pri_ien", 32'(ien), 32'h1);
        seq_t012 = 1'b0; cyc();
        check("pri_r", 32'(r), 32'h1);
        check("pri_vec", 32'(int_vector), 32'h004);
        int_ack = 1'b1; cyc();
        check("ack_r_ien", 32'({r, ien}), 32'h0);
        check("ack_keeps_fgi", 32'(fgi), 32'h8);

        // Held off while sequencer is in T0..T2
        seq_t012 = 1'b1; ien_set = 1'b1; cyc();
        cyc();
        check("seq_hold", 32'(r), 32'h0);
        seq_t012 = 1'b0; cyc();
        check("seq_fall_r", 32'(r), 32'h1);
        check("seq_fall_vec", 32'(int_vector), 32'h004);
        int_ack = 1'b1; seq_t012 = 1'b1; cyc();

        // Masked channel 0 input never interrupts
        bus.cpu_sel = 2'd3; bus.cpu_inp_rd = 1'b1; cyc();
        for (int c = 1; c < 4; c++) begin
            bus.cpu_sel = 2'(c); bus.cpu_wdata = 8'(8'h10 + c);
            bus.cpu_out_wr = 1'b1; cyc();
        end
        bus.cpu_sel = 2'd0; bus.cpu_wdata = 8'h0E; bus.cpu_mask_wr = 1'b1;
        dev_in_data[7:0] = 8'h11; dev_in_valid = 4'b0001; cyc();
        ien_set = 1'b1; seq_t012 = 1'b0; cyc();
        repeat (3) cyc();
        check("mask_block", 32'(r), 32'h0);
        bus.cpu_wdata = 8'hFF; bus.cpu_mask_wr = 1'b1; cyc();
        cyc();
        check("unmask_r", 32'(r), 32'h1);
        check("unmask_vec", 32'(int_vector), 32'h001);
        int_ack = 1'b1; seq_t012 = 1'b1; cyc();

        // ien set/clear conflicts
        ien_set = 1'b1; cyc();
        check("ien_set", 32'(ien), 32'h1);
        ien_set = 1'b1; ien_clr = 1'b1; cyc();
        check("ien_clr_wins", 32'(ien), 32'h0);
        ien_set = 1'b1; cyc();
        ien_set = 1'b1; int_ack = 1'b1; cyc();
        check("ack_beats_set", 32'(ien), 32'h0);

        // Reset aborts pending output
        check("pre_rst_valid", 32'(dev_out_valid), 32'hF);
        reset = 1'b1; cyc();
        check("rst2_valid", 32'(dev_out_valid), 32'h0);
        check("rst2_fgo", 32'(fgo), 32'hF);

        for (int n = 0; n < 3000; n++) begin
            dev_in_valid = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            dev_in_data = 32'($urandom);
            dev_out_ready = 4'($urandom);
            bus.cpu_sel = 2'($urandom);
            bus.cpu_wdata = 8'($urandom);
            bus.cpu_inp_rd = ($urandom_range(0, 3) == 0);
            bus.cpu_out_wr = ($urandom_range(0, 3) == 0);
            bus.cpu_mask_wr = ($urandom_range(0, 15) == 0);
            ien_set = ($urandom_range(0, 3) == 0);
            ien_clr = ($urandom_range(0, 15) == 0);
            int_ack = ($urandom_range(0, 5) == 0);
            seq_t012 = 1'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            cyc();
        end

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
